// File: rtl/sat_pkg.sv
// sat_pkg: shared state encoding, width helper and LFSR tap table for clause selection
package sat_pkg;
   typedef enum logic [2:0] {IDLE, COLLECT, PICK, READ, DONE} state_t;
   localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
   function automatic int cidx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic logic [31:0] lfsr_taps(input int w);
      return (w == 8) ? 32'h0000_00B8 : (w == 32) ? 32'h8020_0003 : 32'(LFSR_TAPS_16);
   endfunction
endpackage

// File: rtl/broken_clause_selector_if.sv
// broken_clause_selector_if: evaluated-clause beats in, selected broken clause out
interface broken_clause_selector_if import sat_pkg::*; #(
   parameter int NUM_CLAUSES = 256
);
   localparam int CIDX_W = cidx_w(NUM_CLAUSES);
   logic              start_i;
   logic              clause_valid_i;
   logic [CIDX_W-1:0] clause_idx_i;
   logic              break_i;
   logic              last_i;
   logic              sel_valid_o;
   logic              sel_ready_i;
   logic [CIDX_W-1:0] sel_idx_o;
   logic              sat_o;
   logic [CIDX_W:0]   broken_cnt_o;
   logic              overflow_o;
   logic              busy_o;
   modport master (
      output start_i, clause_valid_i, clause_idx_i, break_i, last_i, sel_ready_i,
      input  sel_valid_o, sel_idx_o, sat_o, broken_cnt_o, overflow_o, busy_o
   );
   modport slave (
      input  start_i, clause_valid_i, clause_idx_i, break_i, last_i, sel_ready_i,
      output sel_valid_o, sel_idx_o, sat_o, broken_cnt_o, overflow_o, busy_o
   );
endinterface

// File: rtl/lfsr_prng.sv
// lfsr_prng: free-running Galois LFSR; a nonzero seed keeps it out of the all-zero lockup
module lfsr_prng import sat_pkg::*; #(
   parameter int           W     = 16,
   parameter logic [W-1:0] SEED  = W'(16'hACE1),
   parameter int           OUT_W = W
) (
   input  logic             clk_i,
   input  logic             reset_i,
   output logic [OUT_W-1:0] rnd_o
);
   localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));
   logic [W-1:0] state;
   always_ff @(posedge clk_i)
      if (reset_i) state <= SEED;
      else state <= (state >> 1) ^ (state[0] ? TAPS : '0);
   assign rnd_o = state[OUT_W-1:0];
endmodule

// File: rtl/broken_clause_selector.sv
// broken_clause_selector: buffers broken clause indices over a sweep and picks one uniformly
module broken_clause_selector import sat_pkg::*; #(
   parameter int                NUM_CLAUSES = 256,
   parameter int                BUF_DEPTH   = 64,
   parameter int                LFSR_W      = 16,
   parameter logic [LFSR_W-1:0] LFSR_SEED   = LFSR_W'(16'hACE1)
) (
   input logic                     clk_i,
   input logic                     reset_i,
   broken_clause_selector_if.slave bus
);
   localparam int CIDX_W = cidx_w(NUM_CLAUSES);
   localparam int PTR_W  = $clog2(BUF_DEPTH);
   localparam int CNT_W  = CIDX_W + 1;
   localparam logic [CNT_W-1:0] DEPTH = CNT_W'(BUF_DEPTH);
   state_t            state, state_n;
   logic [CIDX_W-1:0] mem [BUF_DEPTH];
   logic [PTR_W-1:0]  r, ptr;
   logic [CNT_W-1:0]  cnt, n, total;
   logic              beat, hit, last_beat, pick_ok;
   lfsr_prng #(.W(LFSR_W), .SEED(LFSR_SEED), .OUT_W(PTR_W)) u_prng (
      .clk_i, .reset_i, .rnd_o(r)
   );
   assign beat      = bus.clause_valid_i && state == COLLECT;
   assign hit       = beat && bus.break_i;
   assign last_beat = beat && bus.last_i;
   assign total     = cnt + CNT_W'(hit);
   // rejection sampling: only draws landing inside the filled part of the buffer count
   assign n         = (cnt > DEPTH) ? DEPTH : cnt;
   assign pick_ok   = CNT_W'(r) < n;
   assign bus.broken_cnt_o = cnt;
   assign bus.busy_o       = state != IDLE;
   always_ff @(posedge clk_i)
      state <= reset_i ? IDLE : state_n;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = bus.start_i ? COLLECT : IDLE;
         COLLECT: state_n = !last_beat ? COLLECT : (total == '0) ? DONE : PICK;
         PICK:    state_n = pick_ok ? READ : PICK;
         READ:    state_n = DONE;
         DONE:    state_n = (bus.sel_valid_o && bus.sel_ready_i) ? IDLE : DONE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk_i)
      if (hit && cnt < DEPTH) mem[cnt[PTR_W-1:0]] <= bus.clause_idx_i;
   always_ff @(posedge clk_i)
      if (reset_i) begin
         cnt             <= '0;
         ptr             <= '0;
         bus.overflow_o  <= 1'b0;
         bus.sat_o       <= 1'b0;
         bus.sel_valid_o <= 1'b0;
         bus.sel_idx_o   <= '0;
      end else begin
         if (state == IDLE && bus.start_i) begin
            cnt            <= '0;
            bus.overflow_o <= 1'b0;
            bus.sat_o      <= 1'b0;
         end
         if (hit) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt >= DEPTH) bus.overflow_o <= 1'b1;
         end
         if (last_beat && total == '0) begin
            bus.sat_o       <= 1'b1;
            bus.sel_idx_o   <= '0;
            bus.sel_valid_o <= 1'b1;
         end
         if (state == PICK && pick_ok) ptr <= r;
         if (state == READ) begin
            bus.sel_idx_o   <= mem[ptr];
            bus.sel_valid_o <= 1'b1;
         end
         if (state == DONE && bus.sel_valid_o && bus.sel_ready_i) bus.sel_valid_o <= 1'b0;
      end
endmodule

// File: tb/tb_broken_clause_selector.sv
// tb_broken_clause_selector: directed sweeps with a queued scoreboard checked by a result monitor
module tb_broken_clause_selector;
   import sat_pkg::*;
   logic clk_i = 1'b0;
   logic reset_i = 1'b1;
   always #5 clk_i = ~clk_i;
   broken_clause_selector_if #(.NUM_CLAUSES(256)) bus ();
   broken_clause_selector #(
      .NUM_CLAUSES(256), .BUF_DEPTH(4), .LFSR_W(16), .LFSR_SEED(16'hACE1)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i), .bus(bus)
   );
   typedef struct {
      int           cnt;
      bit           sat;
      bit           ovf;
      logic [255:0] ok;
   } exp_t;
   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   hist [256];
   bit   pre_valid;
   logic [7:0] hold_idx;
   logic [8:0] hold_cnt;
   task automatic chk(input string nm, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, req);
      end
   endtask
   function automatic logic [255:0] bits(input int a = -1, input int b = -1, input int c = -1,
                                         input int d = -1, input int e = -1, input int f = -1);
      logic [255:0] m;
      int v[6];
      m = '0;
      v = '{a, b, c, d, e, f};
      foreach (v[k]) if (v[k] >= 0) m[v[k]] = 1'b1;
      return m;
   endfunction
   task automatic expect_res(input int cnt, input bit sat, input bit ovf, input logic [255:0] ok);
      exp_t e;
      e.cnt = cnt;
      e.sat = sat;
      e.ovf = ovf;
      e.ok  = ok;
      q.push_back(e);
   endtask
   task automatic wait_idle();
      int i;
      i = 0;
      while (bus.busy_o && i < 500) begin
         @(negedge clk_i);
         i++;
      end
      chk("idle_reached", bus.busy_o, 0);
   endtask
   task automatic sweep(input int nb, input logic [255:0] brk, input bit do_last);
      wait_idle();
      bus.start_i = 1'b1;
      @(posedge clk_i);
      #1 bus.start_i = 1'b0;
      for (int i = 0; i < nb; i++) begin
         bus.clause_valid_i = 1'b1;
         bus.clause_idx_i   = 8'(i);
         bus.break_i        = brk[i];
         bus.last_i         = do_last && (i == nb - 1);
         if (i == nb - 1) pre_valid = bus.sel_valid_o;
         @(posedge clk_i);
         #1;
      end
      bus.clause_valid_i = 1'b0;
      bus.break_i        = 1'b0;
      bus.last_i         = 1'b0;
   endtask
   always @(negedge clk_i)
      if (bus.sel_valid_o && bus.sel_ready_i) begin
         exp_t e;
         if (q.size() == 0) chk("unexpected_result", 1, 0);
         else begin
            e = q.pop_front();
            chk("broken_cnt", bus.broken_cnt_o, e.cnt);
            chk("sat", bus.sat_o, e.sat);
            chk("overflow", bus.overflow_o, e.ovf);
            chk($sformatf("sel_idx_in_set(idx=%0d)", bus.sel_idx_o), e.ok[bus.sel_idx_o], 1);
            if (e.sat) chk("sel_idx_zero_when_sat", bus.sel_idx_o, 0);
            hist[bus.sel_idx_o]++;
         end
      end
   initial begin
      bus.start_i        = 1'b0;
      bus.clause_valid_i = 1'b0;
      bus.clause_idx_i   = '0;
      bus.break_i        = 1'b0;
      bus.last_i         = 1'b0;
      bus.sel_ready_i    = 1'b1;
      repeat (3) @(posedge clk_i);
      #1 reset_i = 1'b0;
      @(negedge clk_i);
      chk("rst_sel_valid", bus.sel_valid_o, 0);
      chk("rst_sat", bus.sat_o, 0);
      chk("rst_cnt", bus.broken_cnt_o, 0);
      chk("rst_overflow", bus.overflow_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_sel_idx", bus.sel_idx_o, 0);
      // a broken last beat while idle must not start anything
      bus.clause_valid_i = 1'b1;
      bus.clause_idx_i   = 8'd3;
      bus.break_i        = 1'b1;
      bus.last_i         = 1'b1;
      @(posedge clk_i);
      #1;
      bus.clause_valid_i = 1'b0;
      bus.break_i        = 1'b0;
      bus.last_i         = 1'b0;
      @(negedge clk_i);
      chk("idle_beat_busy", bus.busy_o, 0);
      chk("idle_beat_cnt", bus.broken_cnt_o, 0);
      chk("idle_beat_valid", bus.sel_valid_o, 0);
      expect_res(2, 1'b0, 1'b0, bits(2, 5));
      sweep(8, bits(2, 5), 1'b1);
      expect_res(0, 1'b1, 1'b0, bits(0));
      sweep(8, '0, 1'b1);
      chk("sat_valid_before_last", pre_valid, 0);
      chk("sat_valid_after_last", bus.sel_valid_o, 1);
      expect_res(6, 1'b0, 1'b1, bits(1, 3, 4, 6));
      sweep(10, bits(1, 3, 4, 6, 8, 9), 1'b1);
      wait_idle();
      bus.sel_ready_i = 1'b0;
      expect_res(2, 1'b0, 1'b0, bits(2, 5));
      sweep(8, bits(2, 5), 1'b1);
      for (int i = 0; i < 200 && !bus.sel_valid_o; i++) @(negedge clk_i);
      chk("hold_valid_seen", bus.sel_valid_o, 1);
      hold_idx = bus.sel_idx_o;
      hold_cnt = bus.broken_cnt_o;
      repeat (10) begin
         @(negedge clk_i);
         chk("hold_valid", bus.sel_valid_o, 1);
         chk("hold_idx", bus.sel_idx_o, hold_idx);
         chk("hold_cnt", bus.broken_cnt_o, hold_cnt);
         chk("hold_flags", {bus.sat_o, bus.overflow_o, bus.busy_o}, 3'b001);
      end
      @(posedge clk_i);
      #1;
      bus.sel_ready_i = 1'b1;
      bus.start_i     = 1'b1;
      @(posedge clk_i);
      #1 bus.start_i = 1'b0;
      @(negedge clk_i);
      chk("accept_busy", bus.busy_o, 0);
      chk("accept_valid", bus.sel_valid_o, 0);
      chk("accept_cnt_kept", bus.broken_cnt_o, 2);
      @(negedge clk_i);
      chk("accept_start_ignored", bus.busy_o, 0);
      sweep(6, bits(0, 1, 2), 1'b0);
      chk("pre_reset_cnt", bus.broken_cnt_o, 3);
      chk("pre_reset_busy", bus.busy_o, 1);
      reset_i = 1'b1;
      @(posedge clk_i);
      #1 reset_i = 1'b0;
      chk("midrst_cnt", bus.broken_cnt_o, 0);
      chk("midrst_busy", bus.busy_o, 0);
      chk("midrst_valid", bus.sel_valid_o, 0);
      chk("midrst_flags", {bus.sat_o, bus.overflow_o}, 0);
      expect_res(1, 1'b0, 1'b0, bits(7));
      sweep(8, bits(7), 1'b1);
      for (int s = 0; s < 1000; s++) begin
         wait_idle();
         @(posedge clk_i);
         #1;
         expect_res(4, 1'b0, 1'b0, bits(10, 20, 30, 40));
         sweep(41, bits(10, 20, 30, 40), 1'b1);
      end
      wait_idle();
      for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk_i);
      chk("queue_drained", q.size(), 0);
      for (int k = 10; k <= 40; k += 10) begin
         checks++;
         if (hist[k] < 150 || hist[k] > 350) begin
            errors++;
            $display("FAIL hist_idx%0d: got %0d picks, expected 150..350", k, hist[k]);
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
